// File: rtl/pe_mutate_lanes.sv
// Substitution processing element: draws a child sequence from the parent sequence and a
// 4x4 probability matrix, LANES sites per cycle, with one independent Galois LFSR per lane.
module pe_mutate_lanes #(
  parameter int NSITE  = 16,
  parameter int LANES  = 4,
  parameter int PW     = 10,
  parameter int ADDR_W = 3,
  parameter int SEED_W = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         seed_valid,
  input  logic [SEED_W-1:0]            seed,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ADDR_W-1:0]            in_addr,
  input  logic [2*NSITE-1:0]           in_seq,
  input  logic [ADDR_W-1:0]            in_child1,
  input  logic [ADDR_W-1:0]            in_child2,
  input  logic [16*PW-1:0]             in_pmat,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ADDR_W-1:0]            out_addr,
  output logic [2*NSITE-1:0]           out_seq,
  output logic [ADDR_W-1:0]            out_child1,
  output logic [ADDR_W-1:0]            out_child2,
  output logic                         out_leaf,
  output logic                         out_gen,
  output logic [$clog2(NSITE+1)-1:0]   out_mcnt
);

  localparam int NBATCH = NSITE / LANES;
  localparam int IDX_W  = (NBATCH > 1) ? $clog2(NBATCH) : 1;
  localparam int MC_W   = $clog2(NSITE + 1);

  typedef enum logic [1:0] {IDLE, GEN, EMIT} state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [15:0]         lfsr_q   [LANES];
  logic [15:0]         lfsr_nxt [LANES];
  logic [ADDR_W-1:0]   addr_q, child1_q, child2_q;
  logic [2*NSITE-1:0]  par_q, wrk_q, gen_seq;
  logic [16*PW-1:0]    pmat_q;
  logic                gen_q;
  logic [MC_W-1:0]     mcnt_q, gen_cnt;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [15:0] lane_seed(input logic [SEED_W-1:0] s, input int j);
    logic [15:0] v;
    v = 16'({s, 8'(j)}) ^ 16'hACE1;
    return (v == 16'h0000) ? 16'h0001 : v;
  endfunction

  // Cumulative selection over pA..pG; pT is implied by the remainder of the range.
  function automatic logic [1:0] draw_base(input logic [PW-1:0] r, input logic [3*PW-1:0] row);
    logic [PW+1:0] rr, s1, s2, s3;
    rr = {2'b00, r};
    s1 = {2'b00, row[PW-1:0]};
    s2 = s1 + {2'b00, row[2*PW-1:PW]};
    s3 = s2 + {2'b00, row[3*PW-1:2*PW]};
    if (rr < s1)      return 2'd0;
    else if (rr < s2) return 2'd1;
    else if (rr < s3) return 2'd2;
    else              return 2'd3;
  endfunction

  assign in_ready = (state_q == IDLE);

  always_comb begin
    gen_seq = wrk_q;
    gen_cnt = mcnt_q;
    for (int j = 0; j < LANES; j++) begin
      int k;
      logic [1:0] pb, nb;
      k  = int'(idx_q) * LANES + j;
      pb = par_q[2*k +: 2];
      nb = draw_base(lfsr_q[j][PW-1:0], pmat_q[4*PW*int'(pb) +: 3*PW]);
      gen_seq[2*k +: 2] = nb;
      if (nb != pb) gen_cnt = gen_cnt + MC_W'(1);
      lfsr_nxt[j] = lfsr_step(lfsr_q[j]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      addr_q     <= '0;
      child1_q   <= '0;
      child2_q   <= '0;
      par_q      <= '0;
      wrk_q      <= '0;
      pmat_q     <= '0;
      gen_q      <= 1'b0;
      mcnt_q     <= '0;
      out_valid  <= 1'b0;
      out_addr   <= '0;
      out_seq    <= '0;
      out_child1 <= '0;
      out_child2 <= '0;
      out_leaf   <= 1'b0;
      out_gen    <= 1'b0;
      out_mcnt   <= '0;
      for (int j = 0; j < LANES; j++) lfsr_q[j] <= lane_seed('0, j);
    end else begin
      case (state_q)
        IDLE: begin
          if (seed_valid)
            for (int j = 0; j < LANES; j++) lfsr_q[j] <= lane_seed(seed, j);
          if (in_valid) begin
            addr_q   <= in_addr;
            child1_q <= in_child1;
            child2_q <= in_child2;
            par_q    <= in_seq;
            wrk_q    <= in_seq;
            pmat_q   <= in_pmat;
            mcnt_q   <= '0;
            idx_q    <= '0;
            if (in_pmat == '0) begin
              gen_q   <= 1'b0;
              state_q <= EMIT;
            end else begin
              gen_q   <= 1'b1;
              state_q <= GEN;
            end
          end
        end
        // ---- GEN: one batch of LANES sites per cycle ----
        GEN: begin
          wrk_q  <= gen_seq;
          mcnt_q <= gen_cnt;
          for (int j = 0; j < LANES; j++) lfsr_q[j] <= lfsr_nxt[j];
          idx_q  <= idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(NBATCH - 1)) state_q <= EMIT;
        end
        // ---- EMIT: publish the packet one cycle after entry, hold until taken ----
        EMIT: begin
          if (!out_valid) begin
            out_valid  <= 1'b1;
            out_addr   <= addr_q;
            out_seq    <= wrk_q;
            out_child1 <= child1_q;
            out_child2 <= child2_q;
            out_leaf   <= (child1_q == '0) && (child2_q == '0);
            out_gen    <= gen_q;
            out_mcnt   <= mcnt_q;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_mutate_lanes.sv
// Directed bench for pe_mutate_lanes with a bench-side LFSR / draw model for generated packets.
module tb_pe_mutate_lanes;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         seed_valid = 1'b0;
  logic [7:0]   seed = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   in_addr = '0;
  logic [31:0]  in_seq = '0;
  logic [2:0]   in_child1 = '0;
  logic [2:0]   in_child2 = '0;
  logic [159:0] in_pmat = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [2:0]   out_addr;
  logic [31:0]  out_seq;
  logic [2:0]   out_child1;
  logic [2:0]   out_child2;
  logic         out_leaf;
  logic         out_gen;
  logic [4:0]   out_mcnt;

  int total = 0;
  int bad   = 0;

  logic [15:0] m_lfsr [4];

  pe_mutate_lanes #(.NSITE(16), .LANES(4), .PW(10), .ADDR_W(3), .SEED_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .seed_valid(seed_valid), .seed(seed),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_seq(in_seq),
    .in_child1(in_child1), .in_child2(in_child2), .in_pmat(in_pmat),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_seq(out_seq),
    .out_child1(out_child1), .out_child2(out_child2), .out_leaf(out_leaf),
    .out_gen(out_gen), .out_mcnt(out_mcnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] m_seed(input logic [7:0] s, input int j);
    logic [15:0] v;
    logic [7:0]  jb;
    jb = 8'(j);
    v = {s, jb} ^ 16'hACE1;
    if (v == 16'h0000) v = 16'h0001;
    return v;
  endfunction

  function automatic logic [15:0] m_step(input logic [15:0] v);
    logic lsb;
    lsb = v[0];
    v = v >> 1;
    if (lsb) v = v ^ 16'hB400;
    return v;
  endfunction

  function automatic logic [1:0] m_pick(input int r, input logic [39:0] row);
    int acc;
    acc = 0;
    for (int c = 0; c < 3; c++) begin
      acc = acc + int'(row[10*c +: 10]);
      if (r < acc) return 2'(c);
    end
    return 2'd3;
  endfunction

  function automatic logic [159:0] mk_pmat(input int pa, input int pc, input int pg, input int pt);
    logic [39:0] row;
    row = {10'(pt), 10'(pg), 10'(pc), 10'(pa)};
    return {row, row, row, row};
  endfunction

  task automatic model_reload(input logic [7:0] s);
    for (int j = 0; j < 4; j++) m_lfsr[j] = m_seed(s, j);
  endtask

  task automatic model_gen(input logic [31:0] par, input logic [159:0] pm,
                           output logic [31:0] exp, output int cnt);
    cnt = 0;
    exp = '0;
    for (int b = 0; b < 4; b++)
      for (int j = 0; j < 4; j++) begin
        int k;
        logic [1:0] pb, nb;
        k  = b * 4 + j;
        pb = par[2*k +: 2];
        nb = m_pick(int'(m_lfsr[j][9:0]), pm[40*int'(pb) +: 40]);
        exp[2*k +: 2] = nb;
        if (nb != pb) cnt++;
        m_lfsr[j] = m_step(m_lfsr[j]);
      end
  endtask

  task automatic send(input logic [2:0] a, input logic [31:0] sq, input logic [2:0] c1,
                      input logic [2:0] c2, input logic [159:0] pm, input logic sv, input logic [7:0] sd);
    in_valid = 1'b1; in_addr = a; in_seq = sq; in_child1 = c1; in_child2 = c2; in_pmat = pm;
    seed_valid = sv; seed = sd;
    @(posedge clk); #1;
    in_valid = 1'b0; seed_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid) break;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_vld_clr"}, 64'(out_valid), 64'd0);
    check({tag, "_rdy_back"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] exp_seq;
    int          exp_cnt;
    logic        seen;

    model_reload(8'h00);
    #12 reset_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_seq", 64'(out_seq), 64'd0);
    check("rst_out_mcnt", 64'(out_mcnt), 64'd0);

    // passthrough
    send(3'd3, 32'h1B1B1B1B, 3'd4, 3'd5, '0, 1'b0, 8'h00);
    check("pt_busy", 64'(in_ready), 64'd0);
    wait_out("pt", 1);
    check("pt_seq", 64'(out_seq), 64'h1B1B1B1B);
    check("pt_gen", 64'(out_gen), 64'd0);
    check("pt_leaf", 64'(out_leaf), 64'd0);
    check("pt_mcnt", 64'(out_mcnt), 64'd0);
    check("pt_addr", 64'(out_addr), 64'd3);
    check("pt_c1", 64'(out_child1), 64'd4);
    check("pt_c2", 64'(out_child2), 64'd5);
    drain("pt");

    // all rows force T
    model_gen(32'h0, mk_pmat(0, 0, 0, 10'h3FF), exp_seq, exp_cnt);
    send(3'd1, 32'h0, 3'd0, 3'd0, mk_pmat(0, 0, 0, 10'h3FF), 1'b0, 8'h00);
    wait_out("allT", 5);
    check("allT_seq", 64'(out_seq), 64'hFFFFFFFF);
    check("allT_mcnt", 64'(out_mcnt), 64'd16);
    check("allT_gen", 64'(out_gen), 64'd1);
    check("allT_leaf", 64'(out_leaf), 64'd1);
    check("allT_model", 64'(exp_seq), 64'hFFFFFFFF);
    drain("allT");

    // pA = 1023: A unless r == 1023
    model_gen(32'h0, mk_pmat(10'h3FF, 0, 0, 0), exp_seq, exp_cnt);
    send(3'd2, 32'h0, 3'd6, 3'd0, mk_pmat(10'h3FF, 0, 0, 0), 1'b0, 8'h00);
    wait_out("pA", 5);
    check("pA_seq", 64'(out_seq), 64'(exp_seq));
    check("pA_mcnt", 64'(out_mcnt), 64'(exp_cnt));
    drain("pA");

    // backpressure then back-to-back passthrough
    model_gen(32'h0, mk_pmat(0, 0, 0, 10'h3FF), exp_seq, exp_cnt);
    send(3'd7, 32'h0, 3'd1, 3'd2, mk_pmat(0, 0, 0, 10'h3FF), 1'b0, 8'h00);
    wait_out("bp", 5);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold_vld", 64'(out_valid), 64'd1);
      check("bp_hold_seq", 64'(out_seq), 64'hFFFFFFFF);
      check("bp_hold_rdy", 64'(in_ready), 64'd0);
    end
    check("bp_addr", 64'(out_addr), 64'd7);
    out_ready = 1'b1;
    in_valid = 1'b1; in_addr = 3'd5; in_seq = 32'h0F0FA5A5; in_child1 = 3'd0; in_child2 = 3'd0;
    in_pmat = '0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_rel_vld", 64'(out_valid), 64'd0);
    check("bp_rel_rdy", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b_accepted", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    check("b2b_vld", 64'(out_valid), 64'd1);
    check("b2b_seq", 64'(out_seq), 64'h0F0FA5A5);
    check("b2b_leaf", 64'(out_leaf), 64'd1);
    drain("b2b");

    // seed reload on the accepting edge, run twice
    model_reload(8'h5A);
    model_gen(32'h1B1B1B1B, mk_pmat(256, 256, 256, 256), exp_seq, exp_cnt);
    send(3'd4, 32'h1B1B1B1B, 3'd2, 3'd3, mk_pmat(256, 256, 256, 256), 1'b1, 8'h5A);
    wait_out("sd1", 5);
    check("sd1_seq", 64'(out_seq), 64'(exp_seq));
    check("sd1_mcnt", 64'(out_mcnt), 64'(exp_cnt));
    drain("sd1");
    model_reload(8'h5A);
    model_gen(32'h1B1B1B1B, mk_pmat(256, 256, 256, 256), exp_seq, exp_cnt);
    send(3'd4, 32'h1B1B1B1B, 3'd2, 3'd3, mk_pmat(256, 256, 256, 256), 1'b1, 8'h5A);
    wait_out("sd2", 5);
    check("sd2_seq", 64'(out_seq), 64'(exp_seq));
    check("sd2_mcnt", 64'(out_mcnt), 64'(exp_cnt));
    drain("sd2");

    // reset mid-GEN discards the packet
    send(3'd1, 32'h0, 3'd0, 3'd0, mk_pmat(0, 0, 0, 10'h3FF), 1'b0, 8'h00);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #3 reset_n = 1'b1;
    model_reload(8'h00);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("rstgen_no_vld", 64'(seen), 64'd0);
    check("rstgen_idle", 64'(in_ready), 64'd1);
    check("rstgen_seq", 64'(out_seq), 64'd0);

    // generation after reset uses the default seed again
    model_gen(32'hE4E4E4E4, mk_pmat(256, 256, 256, 256), exp_seq, exp_cnt);
    send(3'd2, 32'hE4E4E4E4, 3'd1, 3'd0, mk_pmat(256, 256, 256, 256), 1'b0, 8'h00);
    wait_out("post", 5);
    check("post_seq", 64'(out_seq), 64'(exp_seq));
    check("post_mcnt", 64'(out_mcnt), 64'(exp_cnt));
    drain("post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
